// File: rtl/seven_segment_decoder_pkg.sv
// Shared constants for the seven-segment decoder: segment patterns (bit0=a .. bit6=g),
// FSM state encoding, digit-select polarity and the pattern-to-BCD decode function.
package seven_segment_decoder_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam logic DIGIT_TENS  = 1'b1;
    localparam logic DIGIT_UNITS = 1'b0;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        HAVE_TENS = 2'd1,
        PUBLISH   = 2'd2
    } state_e;

    // Returns {pattern_ok, bcd_value}; unknown patterns yield ok=0 and value 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            SEG_0:   res = {1'b1, 4'd0};
            SEG_1:   res = {1'b1, 4'd1};
            SEG_2:   res = {1'b1, 4'd2};
            SEG_3:   res = {1'b1, 4'd3};
            SEG_4:   res = {1'b1, 4'd4};
            SEG_5:   res = {1'b1, 4'd5};
            SEG_6:   res = {1'b1, 4'd6};
            SEG_7:   res = {1'b1, 4'd7};
            SEG_8:   res = {1'b1, 4'd8};
            SEG_9:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seven_segment_decoder_sync2.sv
// Two-flop synchronizer for one asynchronous bit; both stages clear asynchronously.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/seven_segment_decoder.sv
// Captures a multiplexed two-digit seven-segment bus and publishes tens/units BCD pairs.
// Optional sticky error output is enabled by defining SEVEN_SEGMENT_DECODER_ERR_EN.
module seven_segment_decoder
    import seven_segment_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          INVERT        = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] segments,
    input  logic       digit,
    output logic [3:0] ten_count,
    output logic [3:0] unit_count,
`ifdef SEVEN_SEGMENT_DECODER_ERR_EN
    output logic       error,
`endif
    output logic       valid
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] ACC_AT  = 4'(STABLE_CYCLES - 2);

    logic       rst_sync_n;
    logic [7:0] bus_raw_s;
    logic [7:0] bus_sync_s;
    logic [7:0] prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic       same_s;
    logic       accept_s;
    logic [6:0] seg_eff_s;
    logic       dec_ok_s;
    logic [3:0] dec_val_s;
    logic       is_tens_s;
    state_e     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ten_count_q, ten_count_d;
    logic [3:0] unit_count_q, unit_count_d;
    logic       valid_q, valid_d;

    // Reset asserts immediately but releases only after two clean clock edges.
    sync2 u_rst_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (1'b1),
        .q_o   (rst_sync_n)
    );

    assign bus_raw_s = {digit, segments};

    for (genvar i = 0; i < 8; i++) begin : g_sync
        sync2 u_sync (
            .clk   (clk),
            .rst_n (rst_sync_n),
            .d_i   (bus_raw_s[i]),
            .q_o   (bus_sync_s[i])
        );
    end

    assign same_s    = (bus_sync_s == prev_q);
    assign accept_s  = same_s && (cnt_q == ACC_AT);
    assign seg_eff_s = INVERT ? ~bus_sync_s[6:0] : bus_sync_s[6:0];
    assign {dec_ok_s, dec_val_s} = seg_decode(seg_eff_s);
    assign is_tens_s = (bus_sync_s[7] == DIGIT_TENS);

    // Stability run length of the synchronized bus, saturating once accepted.
    always_comb begin
        cnt_d = cnt_q;
        if (!same_s) begin
            cnt_d = 4'd0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Units acceptance loads the outputs directly so valid appears in the PUBLISH cycle.
    always_comb begin
        state_d      = state_q;
        tens_d       = tens_q;
        ten_count_d  = ten_count_q;
        unit_count_d = unit_count_q;
        valid_d      = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept_s && dec_ok_s && is_tens_s) begin
                    tens_d  = dec_val_s;
                    state_d = HAVE_TENS;
                end else begin
                    state_d = HUNT;
                end
            end
            HAVE_TENS: begin
                if (accept_s && !dec_ok_s) begin
                    tens_d  = 4'd0;
                    state_d = HUNT;
                end else if (accept_s && is_tens_s) begin
                    tens_d  = dec_val_s;
                    state_d = HAVE_TENS;
                end else if (accept_s) begin
                    ten_count_d  = tens_q;
                    unit_count_d = dec_val_s;
                    valid_d      = 1'b1;
                    state_d      = PUBLISH;
                end else begin
                    state_d = HAVE_TENS;
                end
            end
            PUBLISH: begin
                state_d = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, run counter, holding and output registers.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            prev_q       <= 8'd0;
            cnt_q        <= 4'd0;
            state_q      <= HUNT;
            tens_q       <= 4'd0;
            ten_count_q  <= 4'd0;
            unit_count_q <= 4'd0;
            valid_q      <= 1'b0;
        end else begin
            prev_q       <= bus_sync_s;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            tens_q       <= tens_d;
            ten_count_q  <= ten_count_d;
            unit_count_q <= unit_count_d;
            valid_q      <= valid_d;
        end
    end

`ifdef SEVEN_SEGMENT_DECODER_ERR_EN
    logic error_q;
    logic err_set_s;

    assign err_set_s = accept_s && !dec_ok_s;

    // Sticky: only reset clears it.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_q | err_set_s;
        end
    end

    assign error = error_q;
`endif

    assign ten_count  = ten_count_q;
    assign unit_count = unit_count_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench: stimulus pushes expected tens/units pairs, a monitor pops them on each valid pulse.
module tb_seven_segment_decoder;

    logic       clk;
    logic       reset_n;
    logic [6:0] segments;
    logic       digit;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       valid;
`ifdef SEVEN_SEGMENT_DECODER_ERR_EN
    logic       error;
`endif

    seven_segment_decoder #(.STABLE_CYCLES(4), .INVERT(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .segments   (segments),
        .digit      (digit),
        .ten_count  (ten_count),
        .unit_count (unit_count),
`ifdef SEVEN_SEGMENT_DECODER_ERR_EN
        .error      (error),
`endif
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         pulses = 0;
    int         expected_pulses = 0;
    logic [7:0] exp_q[$];
    logic       valid_prev = 1'b0;

    // Active-low bus values (INVERT=1).
    localparam logic [6:0] BUS_0   = 7'h40;
    localparam logic [6:0] BUS_2   = 7'h24;
    localparam logic [6:0] BUS_3   = 7'h30;
    localparam logic [6:0] BUS_8   = 7'h00;
    localparam logic [6:0] BUS_9   = 7'h10;
    localparam logic [6:0] BUS_BAD = 7'h7E;

    task automatic check(input string name, input int actual, input int required);
        tests_run++;
        if (actual != required) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic d, input int n);
        segments = s;
        digit    = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pair(input logic [3:0] t, input logic [3:0] u);
        exp_q.push_back({t, u});
        expected_pulses++;
    endtask

    // Monitor: every valid pulse is matched against the oldest expected pair.
    always @(negedge clk) begin
        if (valid) begin
            pulses++;
            tests_run++;
            if (valid_prev) begin
                tests_failed++;
                $display("FAIL valid_width: got pulse of 2+ cycles, required 1 cycle");
            end
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_valid: got %0d/%0d, required no pulse", ten_count, unit_count);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                tests_run++;
                if ({ten_count, unit_count} != e) begin
                    tests_failed++;
                    $display("FAIL publish_pair: got %0d/%0d, required %0d/%0d",
                             ten_count, unit_count, e[7:4], e[3:0]);
                end
            end
        end
        valid_prev = valid;
    end

    initial begin
        reset_n  = 1'b0;
        segments = BUS_0;
        digit    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ten", int'(ten_count), 0);
        check("reset_unit", int'(unit_count), 0);
        check("reset_valid", int'(valid), 0);
`ifdef SEVEN_SEGMENT_DECODER_ERR_EN
        check("reset_error", int'(error), 0);
`endif
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic tens 2 then units 3.
        expect_pair(4'd2, 4'd3);
        drive(BUS_2, 1'b1, 10);
        drive(BUS_3, 1'b0, 10);
        check("basic_ten_after", int'(ten_count), 2);

        // Reset while holding tens: outputs clear at once, following units run is ignored.
        drive(BUS_2, 1'b1, 10);
        reset_n = 1'b0;
        #1;
        check("midreset_ten", int'(ten_count), 0);
        check("midreset_unit", int'(unit_count), 0);
        check("midreset_valid", int'(valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(BUS_3, 1'b0, 10);

        // Tens held only 3 cycles: never accepted.
        drive(BUS_2, 1'b1, 3);
        drive(BUS_3, 1'b0, 10);

        // Units-first is ignored; publish follows the tens-then-units pair.
        drive(BUS_3, 1'b0, 10);
        expect_pair(4'd2, 4'd3);
        drive(BUS_2, 1'b1, 10);
        drive(BUS_3, 1'b0, 10);

        // All segments lit decodes as 8.
        expect_pair(4'd8, 4'd3);
        drive(BUS_8, 1'b1, 10);
        drive(BUS_3, 1'b0, 10);

        // Invalid tens pattern aborts the pair.
        drive(BUS_2, 1'b1, 10);
        drive(BUS_BAD, 1'b1, 10);
        drive(BUS_3, 1'b0, 10);
        check("invalid_keeps_ten", int'(ten_count), 8);
        check("invalid_keeps_unit", int'(unit_count), 3);
`ifdef SEVEN_SEGMENT_DECODER_ERR_EN
        check("invalid_error", int'(error), 1);
`endif

        // Continuous multiplex 9/9, 16 cycles per digit.
        for (int f = 0; f < 8; f++) begin
            expect_pair(4'd9, 4'd9);
            drive(BUS_9, 1'b1, 16);
            drive(BUS_9, 1'b0, 16);
        end
        repeat (20) @(negedge clk);

        check("final_ten", int'(ten_count), 9);
        check("final_unit", int'(unit_count), 9);
        check("scoreboard_drained", exp_q.size(), 0);
        check("pulse_count", pulses, expected_pulses);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
